// File: rtl/ccip_c0_rd_arb_if.sv
// Bus bundle between the AFU request ports, the C0 Tx/Rx shell channel and the
// read arbiter. The arbiter takes the slave view; the surrounding fabric takes the master view.
interface ccip_c0_rd_arb_if #(
    parameter int NUM_PORTS = 4
);
    logic [NUM_PORTS-1:0]    port_req_valid;
    logic [NUM_PORTS*74-1:0] port_req_hdr;
    logic [NUM_PORTS-1:0]    port_req_ready;
    logic                    c0_tx_valid;
    logic [73:0]             c0_tx_hdr;
    logic                    c0TxAlmFull;
    logic                    c0_rx_rspValid;
    logic [27:0]             c0_rx_hdr;
    logic [511:0]            c0_rx_data;
    logic [NUM_PORTS-1:0]    port_rsp_valid;
    logic [27:0]             port_rsp_hdr;
    logic [511:0]            port_rsp_data;
    logic [NUM_PORTS*8-1:0]  port_outstanding;

    modport slave (
        input  port_req_valid, port_req_hdr, c0TxAlmFull,
               c0_rx_rspValid, c0_rx_hdr, c0_rx_data,
        output port_req_ready, c0_tx_valid, c0_tx_hdr,
               port_rsp_valid, port_rsp_hdr, port_rsp_data, port_outstanding
    );

    modport master (
        output port_req_valid, port_req_hdr, c0TxAlmFull,
               c0_rx_rspValid, c0_rx_hdr, c0_rx_data,
        input  port_req_ready, c0_tx_valid, c0_tx_hdr,
               port_rsp_valid, port_rsp_hdr, port_rsp_data, port_outstanding
    );
endinterface

// File: rtl/ccip_c0_rd_arb.sv
// N-port CCI-P C0 read-request arbiter: per-port FIFOs, round-robin issue with
// per-port line credits, and tag-based steering of read responses back to their port.
module ccip_c0_rd_arb #(
    parameter int NUM_PORTS  = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int MAX_OUT    = 64
) (
    input  logic            pClk,
    input  logic            pck_cp2af_softReset,
    ccip_c0_rd_arb_if.slave bus
);
    localparam int IDX_W = ($clog2(NUM_PORTS) > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [3:0] RSP_RDLINE = 4'h0;

    function automatic logic [2:0] hdr_lines(input logic [73:0] h);
        case (h[69:68])
            2'b01:   return 3'd2;
            2'b11:   return 3'd4;
            default: return 3'd1;
        endcase
    endfunction

    logic [73:0]          fifo_mem [NUM_PORTS][FIFO_DEPTH];
    logic [PTR_W-1:0]     rd_ptr   [NUM_PORTS];
    logic [PTR_W-1:0]     wr_ptr   [NUM_PORTS];
    logic [CNT_W-1:0]     count    [NUM_PORTS];
    logic [CNT_W-1:0]     count_nxt[NUM_PORTS];
    logic [73:0]          head     [NUM_PORTS];
    logic [2:0]           head_lines[NUM_PORTS];
    logic [7:0]           outstanding[NUM_PORTS];
    logic [8:0]           out_sum  [NUM_PORTS];
    logic [NUM_PORTS-1:0] ready_q, push, pop, elig, rsp_dec;

    logic [IDX_W-1:0]     rr_ptr, grant_idx, cand;
    logic                 grant;
    logic [73:0]          tx_hdr_nxt;

    logic [IDX_W-1:0]     rx_tag;
    logic                 rsp_fwd;
    logic [27:0]          rsp_hdr_nxt;

    logic                 tx_valid_q;
    logic [73:0]          tx_hdr_q;
    logic [NUM_PORTS-1:0] rsp_valid_q;
    logic [27:0]          rsp_hdr_q;
    logic [511:0]         rsp_data_q;

    assign push = bus.port_req_valid & ready_q;

    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            head[i]       = fifo_mem[i][rd_ptr[i]];
            head_lines[i] = hdr_lines(head[i]);
            elig[i]       = (count[i] != '0) &&
                            (({1'b0, outstanding[i]} + 9'(head_lines[i])) <= 9'(MAX_OUT));
        end
    end

    // First eligible port strictly after the last winner, wrapping.
    always_comb begin
        grant     = 1'b0;
        grant_idx = '0;
        cand      = '0;
        if (!bus.c0TxAlmFull) begin
            for (int k = 1; k <= NUM_PORTS; k++) begin
                cand = IDX_W'((int'(rr_ptr) + k) % NUM_PORTS);
                if (!grant && elig[cand]) begin
                    grant     = 1'b1;
                    grant_idx = cand;
                end
            end
        end
        tx_hdr_nxt                = head[grant_idx];
        tx_hdr_nxt[15 -: IDX_W]   = grant_idx;
    end

    assign rx_tag  = bus.c0_rx_hdr[15 -: IDX_W];
    assign rsp_fwd = bus.c0_rx_rspValid && (bus.c0_rx_hdr[19:16] == RSP_RDLINE) &&
                     (int'(rx_tag) < NUM_PORTS);

    always_comb begin
        rsp_hdr_nxt              = bus.c0_rx_hdr;
        rsp_hdr_nxt[15 -: IDX_W] = '0;
    end

    // Grant and response decrement on the same port both apply; the decrement floors at 0.
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            pop[i]       = grant && (grant_idx == IDX_W'(i));
            rsp_dec[i]   = rsp_fwd && (rx_tag == IDX_W'(i));
            count_nxt[i] = count[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
            out_sum[i]   = {1'b0, outstanding[i]} + (pop[i] ? 9'(head_lines[i]) : 9'd0);
            if (rsp_dec[i] && (out_sum[i] != 9'd0))
                out_sum[i] = out_sum[i] - 9'd1;
        end
    end

    always_ff @(posedge pClk) begin
        for (int i = 0; i < NUM_PORTS; i++)
            if (push[i]) fifo_mem[i][wr_ptr[i]] <= bus.port_req_hdr[i*74 +: 74];
    end

    always_ff @(posedge pClk) begin
        if (pck_cp2af_softReset) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                rd_ptr[i]      <= '0;
                wr_ptr[i]      <= '0;
                count[i]       <= '0;
                outstanding[i] <= '0;
            end
            ready_q     <= '0;
            rr_ptr      <= IDX_W'(NUM_PORTS - 1);
            tx_valid_q  <= 1'b0;
            tx_hdr_q    <= '0;
            rsp_valid_q <= '0;
            rsp_hdr_q   <= '0;
            rsp_data_q  <= '0;
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
                if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
                count[i]       <= count_nxt[i];
                ready_q[i]     <= (count_nxt[i] != CNT_W'(FIFO_DEPTH));
                outstanding[i] <= out_sum[i][7:0];
            end
            tx_valid_q <= grant;
            if (grant) begin
                tx_hdr_q <= tx_hdr_nxt;
                rr_ptr   <= grant_idx;
            end
            rsp_valid_q <= rsp_fwd ? (NUM_PORTS'(1) << rx_tag) : '0;
            if (rsp_fwd) begin
                rsp_hdr_q  <= rsp_hdr_nxt;
                rsp_data_q <= bus.c0_rx_data;
            end
        end
    end

    assign bus.port_req_ready = ready_q;
    assign bus.c0_tx_valid    = tx_valid_q;
    assign bus.c0_tx_hdr      = tx_hdr_q;
    assign bus.port_rsp_valid = rsp_valid_q;
    assign bus.port_rsp_hdr   = rsp_hdr_q;
    assign bus.port_rsp_data  = rsp_data_q;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_out
        assign bus.port_outstanding[i*8 +: 8] = outstanding[i];
    end
endmodule

// File: tb/tb_ccip_c0_rd_arb.sv
// Randomized bench for ccip_c0_rd_arb: a queue-based reference model predicts
// Tx issue order, credits, readiness and response steering every cycle.
module tb_ccip_c0_rd_arb;
    localparam int N  = 4;
    localparam int D  = 8;
    localparam int MO = 4;

    typedef logic [73:0] hdr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ccip_c0_rd_arb_if #(.NUM_PORTS(N)) bus ();

    ccip_c0_rd_arb #(.NUM_PORTS(N), .FIFO_DEPTH(D), .MAX_OUT(MO)) dut (
        .pClk                (clk),
        .pck_cp2af_softReset (rst),
        .bus                 (bus)
    );

    // stimulus for the next cycle
    logic         d_rst;
    logic [N-1:0] d_valid;
    hdr_t         d_hdr [N];
    logic         d_alm;
    logic         d_rv;
    logic [27:0]  d_rhdr;
    logic [511:0] d_rdata;

    // reference model state
    hdr_t         mq [N][$];
    int           mout [N];
    int           mlast;
    bit           mrdy [N];
    bit           ex_tx_v;
    hdr_t         ex_tx_hdr;
    logic [N-1:0] ex_rsp_v;
    logic [27:0]  ex_rsp_hdr;
    logic [511:0] ex_rsp_data;
    int           pend [$];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic int lines_of(input hdr_t h);
        case (h[69:68])
            2'b01:   return 2;
            2'b11:   return 4;
            default: return 1;
        endcase
    endfunction

    function automatic hdr_t rand_hdr();
        return {10'($urandom()), 32'($urandom()), 32'($urandom())};
    endfunction

    task automatic model_step();
        int   g;
        int   t;
        int   p;
        hdr_t h;
        g = -1;
        if (d_rst) begin
            for (int i = 0; i < N; i++) begin
                mq[i].delete();
                mout[i] = 0;
                mrdy[i] = 1'b0;
            end
            mlast       = N - 1;
            ex_tx_v     = 1'b0;
            ex_tx_hdr   = '0;
            ex_rsp_v    = '0;
            ex_rsp_hdr  = '0;
            ex_rsp_data = '0;
            return;
        end
        if (!d_alm) begin
            for (int k = 1; k <= N; k++) begin
                p = (mlast + k) % N;
                if (g < 0 && mq[p].size() > 0 && mout[p] + lines_of(mq[p][0]) <= MO) g = p;
            end
        end
        ex_tx_v = (g >= 0);
        if (g >= 0) begin
            h         = mq[g].pop_front();
            h[15:14]  = g[1:0];
            ex_tx_hdr = h;
            mout[g]  += lines_of(h);
            mlast     = g;
            for (int l = 0; l < lines_of(h); l++) pend.push_back(g);
        end
        ex_rsp_v = '0;
        if (d_rv && d_rhdr[19:16] == 4'h0) begin
            t = int'(d_rhdr[15:14]);
            if (mout[t] > 0) mout[t]--;
            ex_rsp_v           = N'(1) << t;
            ex_rsp_hdr         = d_rhdr;
            ex_rsp_hdr[15:14]  = 2'b00;
            ex_rsp_data        = d_rdata;
        end
        for (int i = 0; i < N; i++)
            if (d_valid[i] && mrdy[i]) mq[i].push_back(d_hdr[i]);
        for (int i = 0; i < N; i++)
            mrdy[i] = (mq[i].size() != D);
    endtask

    task automatic compare();
        chk("tx_valid", 512'(bus.c0_tx_valid), 512'(ex_tx_v));
        if (ex_tx_v) chk("tx_hdr", 512'(bus.c0_tx_hdr), 512'(ex_tx_hdr));
        chk("rsp_valid", 512'(bus.port_rsp_valid), 512'(ex_rsp_v));
        if (ex_rsp_v != '0) begin
            chk("rsp_hdr", 512'(bus.port_rsp_hdr), 512'(ex_rsp_hdr));
            chk("rsp_data", bus.port_rsp_data, ex_rsp_data);
        end
        for (int i = 0; i < N; i++) begin
            chk($sformatf("ready[%0d]", i), 512'(bus.port_req_ready[i]), 512'(mrdy[i]));
            chk($sformatf("outstanding[%0d]", i), 512'(bus.port_outstanding[i*8 +: 8]),
                512'(mout[i]));
        end
    endtask

    task automatic step();
        rst                = d_rst;
        bus.port_req_valid = d_valid;
        for (int i = 0; i < N; i++) bus.port_req_hdr[i*74 +: 74] = d_hdr[i];
        bus.c0TxAlmFull    = d_alm;
        bus.c0_rx_rspValid = d_rv;
        bus.c0_rx_hdr      = d_rhdr;
        bus.c0_rx_data     = d_rdata;
        model_step();
        @(posedge clk);
        @(negedge clk);
        compare();
    endtask

    task automatic idle();
        d_rst   = 1'b0;
        d_valid = '0;
        d_alm   = 1'b0;
        d_rv    = 1'b0;
        d_rhdr  = 28'($urandom());
        d_rdata = {16{$urandom()}};
        for (int i = 0; i < N; i++) d_hdr[i] = rand_hdr();
    endtask

    // Returns pending lines out of order, with occasional ignored traffic.
    task automatic rand_rsp();
        int r;
        int idx;
        int t;
        r = $urandom_range(0, 99);
        if (pend.size() > 0 && r < 45) begin
            idx = $urandom_range(0, pend.size() - 1);
            t   = pend[idx];
            pend.delete(idx);
            d_rv           = 1'b1;
            d_rhdr[19:16]  = 4'h0;
            d_rhdr[15:14]  = t[1:0];
        end else if (r >= 95) begin
            d_rv          = 1'b1;
            d_rhdr[19:16] = r[0] ? 4'h4 : 4'h1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int alm_left;
        int rate;
        alm_left = 0;
        rate     = 2;
        mlast    = N - 1;
        idle();
        d_rst = 1'b1;
        repeat (3) step();
        chk("rst_tx_hdr", 512'(bus.c0_tx_hdr), 512'(0));
        chk("rst_rsp_hdr", 512'(bus.port_rsp_hdr), 512'(0));
        chk("rst_ready", 512'(bus.port_req_ready), 512'(0));

        idle();
        step();
        chk("ready_after_rst", 512'(bus.port_req_ready), 512'(4'hF));

        // single push on port 2: Tx two cycles later with the port tag in mdata
        idle();
        d_valid[2] = 1'b1;
        d_hdr[2]   = {2'b00, 2'b00, 2'b00, 4'h0, 6'h0, 42'h100, 16'h0005};
        step();
        idle();
        step();
        chk("dir_tx_valid", 512'(bus.c0_tx_valid), 512'(1));
        chk("dir_tx_mdata", 512'(bus.c0_tx_hdr[15:0]), 512'(16'h8005));
        chk("dir_out2", 512'(bus.port_outstanding[23:16]), 512'(1));

        idle();
        d_rv   = 1'b1;
        d_rhdr = 28'h000C123;
        step();
        chk("dir_rsp_valid", 512'(bus.port_rsp_valid), 512'(4'b1000));
        chk("dir_rsp_mdata", 512'(bus.port_rsp_hdr[15:0]), 512'(16'h0123));
        idle();
        d_rv   = 1'b1;
        d_rhdr = 28'h004C123;
        step();
        chk("dir_umsg", 512'(bus.port_rsp_valid), 512'(0));

        // all ports push three single-line requests after a fresh reset
        idle();
        d_rst = 1'b1;
        step();
        idle();
        step();
        for (int r = 0; r < 3; r++) begin
            idle();
            d_valid = '1;
            for (int i = 0; i < N; i++) d_hdr[i][69:68] = 2'b00;
            step();
        end
        for (int c = 0; c < 14; c++) begin
            idle();
            step();
        end

        // fill port 0 under almost-full, offer a ninth, then drain
        for (int c = 0; c < 9; c++) begin
            idle();
            d_alm      = 1'b1;
            d_valid[0] = 1'b1;
            step();
        end
        chk("fill_ready0", 512'(bus.port_req_ready[0]), 512'(0));
        for (int c = 0; c < 60; c++) begin
            idle();
            rand_rsp();
            step();
        end

        for (int c = 0; c < 3000; c++) begin
            idle();
            if (c % 500 == 0) rate = $urandom_range(1, 4);
            d_rst = ($urandom_range(0, 399) == 0);
            if (alm_left > 0) alm_left--;
            else if ($urandom_range(0, 39) == 0) alm_left = $urandom_range(1, 12);
            d_alm = (alm_left > 0);
            for (int i = 0; i < N; i++) d_valid[i] = ($urandom_range(0, 4) < rate);
            rand_rsp();
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
